// File: rtl/systemverilog_bus_mux.sv
// systemverilog_bus_mux: serializes one 32-bit adr/dat bus transaction into an 8-byte valid/ready stream packet
module systemverilog_bus_mux (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_vld,
    input  logic [31:0] bus_adr,
    input  logic [31:0] bus_dat,
    output logic        bus_rdy,
    output logic        str_vld,
    output logic [7:0]  str_bus,
    input  logic        str_rdy
);
    typedef enum logic {IDLE, SEND} state_t;
    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [63:0] pkt_q, pkt_d;
    logic        bus_trn, str_trn, last;
    // handshakes and outputs; a new transaction is taken while idle or as the last byte leaves
    always_comb begin
        last    = state_q == SEND && cnt_q == 3'd7;
        str_vld = state_q == SEND;
        str_bus = str_vld ? pkt_q[{cnt_q, 3'b000} +: 8] : 8'h00;
        bus_rdy = !rst && (state_q == IDLE || (last && str_rdy));
        bus_trn = bus_vld && bus_rdy;
        str_trn = str_vld && str_rdy;
    end
    // next state: load on acceptance, step the byte index per transfer, drop to idle after the last byte
    always_comb begin
        pkt_d   = bus_trn ? {bus_dat, bus_adr} : pkt_q;
        cnt_d   = bus_trn ? 3'd0 : str_trn ? (last ? 3'd0 : cnt_q + 3'd1) : cnt_q;
        state_d = bus_trn ? SEND : (str_trn && last) ? IDLE : state_q;
    end
    // state registers, cleared asynchronously so a reset abandons any packet in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            pkt_q   <= 64'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pkt_q   <= pkt_d;
        end
    end
endmodule

// File: tb/tb_systemverilog_bus_mux.sv
// tb_systemverilog_bus_mux: table vectors, corner sequences and random loopback against a byte-queue model
module tb_systemverilog_bus_mux;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bus_vld = 1'b0;
    logic [31:0] bus_adr = '0;
    logic [31:0] bus_dat = '0;
    logic        str_rdy = 1'b0;
    logic        bus_rdy, str_vld;
    logic [7:0]  str_bus;

    systemverilog_bus_mux dut (
        .clk(clk), .rst(rst), .bus_vld(bus_vld), .bus_adr(bus_adr), .bus_dat(bus_dat),
        .bus_rdy(bus_rdy), .str_vld(str_vld), .str_bus(str_bus), .str_rdy(str_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [31:0] adr;
        logic [31:0] dat;
        logic        srdy;
        logic        e_rdy;
        logic        e_vld;
        logic [7:0]  e_bus;
    } vec_t;

    int          vectors = 0;
    int          errors  = 0;
    logic [7:0]  exp_q[$];
    logic [63:0] pair_q[$];
    logic [63:0] rx = '0;
    int          rx_n = 0;
    int          accepted = 0;
    vec_t        tbl[$];

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got rdy/vld/bus=%b/%b/%h, expected %b/%b/%h",
                     name, act[9], act[8], act[7:0], req[9], req[8], req[7:0]);
        end
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // one clock: drive inputs, compare against the queue model, then advance the model
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d, input logic s);
        logic       er, ev;
        logic [7:0] eb;
        logic [63:0] p;
        @(negedge clk);
        bus_vld = v; bus_adr = a; bus_dat = d; str_rdy = s;
        #1;
        ev = exp_q.size() != 0;
        eb = ev ? exp_q[0] : 8'h00;
        er = !ev || (exp_q.size() == 1 && s);
        check("step", {bus_rdy, str_vld, str_bus}, {er, ev, eb});
        if (str_vld && str_rdy) begin
            rx = {str_bus, rx[63:8]};
            rx_n++;
            if (rx_n == 8) begin
                rx_n = 0;
                if (pair_q.size() == 0) check64("loopback_extra", rx, 64'hx);
                else check64("loopback", rx, pair_q.pop_front());
            end
        end
        if (ev && s) void'(exp_q.pop_front());
        if (v && er) begin
            p = {d, a};
            for (int k = 0; k < 8; k++) exp_q.push_back(p[8*k +: 8]);
            pair_q.push_back(p);
            accepted++;
        end
    endtask

    task automatic add(input logic v, input logic [31:0] a, input logic [31:0] d, input logic s,
                       input logic er, input logic ev, input logic [7:0] eb);
        vec_t t;
        t.vld = v; t.adr = a; t.dat = d; t.srdy = s; t.e_rdy = er; t.e_vld = ev; t.e_bus = eb;
        tbl.push_back(t);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(1'b0, '0, '0, 1'b1);
        step(1'b0, '0, '0, 1'b1);
    endtask

    initial begin
        logic [7:0] s1[8];
        logic [7:0] s2[16];
        s1 = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        s2 = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
               8'h03, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00};
        // single write
        add(1, 32'h1234_5678, 32'hDEAD_BEEF, 1, 1, 0, 8'h00);
        for (int i = 0; i < 8; i++) add(0, '0, '0, 1, i == 7, 1, s1[i]);
        add(0, '0, '0, 1, 1, 0, 8'h00);
        // back-to-back, second request held pending until the byte-7 transfer
        add(1, 32'd1, 32'd2, 1, 1, 0, 8'h00);
        for (int i = 0; i < 8; i++) add(1, 32'd3, 32'd4, 1, i == 7, 1, s2[i]);
        for (int i = 8; i < 16; i++) add(0, '0, '0, 1, i == 15, 1, s2[i]);
        add(0, '0, '0, 1, 1, 0, 8'h00);

        #1;
        check("in_reset", {bus_rdy, str_vld, str_bus}, 10'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].vld, tbl[i].adr, tbl[i].dat, tbl[i].srdy);
            check($sformatf("table[%0d]", i), {bus_rdy, str_vld, str_bus},
                  {tbl[i].e_rdy, tbl[i].e_vld, tbl[i].e_bus});
        end

        // backpressure at 50%
        step(1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) step(1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)));
        drain();

        // stall on the last byte with a request waiting
        step(1'b1, 32'hA5A5_0001, 32'h5A5A_0002, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 32'hCAFE_0003, 32'hF00D_0004, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'hCAFE_0003, 32'hF00D_0004, 1'b0);
            check("stall_last_rdy", {bus_rdy, 9'b0}, 10'b0);
        end
        step(1'b1, 32'hCAFE_0003, 32'hF00D_0004, 1'b1);
        check("stall_release_rdy", {bus_rdy, 9'b0}, {1'b1, 9'b0});
        drain();

        // reset mid-packet after byte 3
        step(1'b1, 32'h0BAD_0BAD, 32'h1111_2222, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1);
        @(negedge clk);
        bus_vld = 1'b0;
        #2 rst = 1'b1;
        #1 check("reset_mid", {bus_rdy, str_vld, str_bus}, 10'b0);
        exp_q.delete(); pair_q.delete(); rx_n = 0;
        @(negedge clk);
        rst = 1'b0;
        #1 check("after_release", {bus_rdy, str_vld, str_bus}, {1'b1, 9'b0});
        step(1'b1, 32'h7654_3210, 32'h0F1E_2D3C, 1'b1);
        drain();

        // random loopback of 100 pairs
        accepted = 0;
        for (int i = 0; i < 5000 && accepted < 100; i++)
            step($urandom_range(0, 9) < 7, $urandom, $urandom, $urandom_range(0, 9) < 7);
        check64("loopback_count", 64'(accepted), 64'd100);
        drain();
        check64("loopback_leftover", 64'(pair_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/systemverilog_bus_mux.md
# systemverilog_bus_mux

Bus-to-stream serializer: accepts one 32-bit address/data bus transaction and emits it as an 8-byte packet on a valid/ready byte stream. It sits directly upstream of the stream-to-bus demux stage, whose packet format it produces. It is also the transmit side of a bus-over-byte-link tunnel.

## Interface

Parameters:
- none; packet length is fixed at 8 bytes, address first.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- bus_vld  input  1  transaction valid (chip select)
- bus_adr  input  32  address
- bus_dat  input  32  write data
- bus_rdy  output  1  ready (acknowledge); transaction accepted when bus_vld & bus_rdy
- str_vld  output  1  stream byte valid
- str_bus  output  8  stream byte
- str_rdy  input  1  stream ready; byte transferred when str_vld & str_rdy

## Operation

- Definitions: bus_trn = bus_vld & bus_rdy; str_trn = str_vld & str_rdy.
- State:
  - 64-bit packet register pkt = {dat, adr}
  - 3-bit byte counter cnt
  - FSM with states IDLE and SEND
- Byte order on the stream: byte k = pkt[8k+7:8k]:
  - bytes 0..3 are adr[7:0]..adr[31:24]
  - bytes 4..7 are dat[7:0]..dat[31:24]
- IDLE:
  - bus_rdy=1 and str_vld=0.
  - On bus_trn: pkt<={bus_dat,bus_adr}, cnt<=0, go to SEND.
- SEND:
  - str_vld=1 and str_bus=pkt byte[cnt].
  - On str_trn with cnt<7: cnt<=cnt+1.
- Last byte (SEND, cnt==7):
  - bus_rdy = str_rdy, a combinational path from str_rdy.
  - On str_trn & bus_vld: load a new pkt, cnt wraps to 0, stay in SEND (back-to-back, no bubble).
  - On str_trn & !bus_vld: go to IDLE.
- In SEND with cnt<7: bus_rdy=0.
- bus_rdy = !rst & (IDLE | (cnt==7 & str_rdy)).
- Stream protocol:
  - Once str_vld is asserted it stays high until str_trn.
  - str_bus is stable while str_vld & !str_rdy.
  - str_rdy may toggle arbitrarily. A stall holds cnt and pkt unchanged.
- Bus inputs are sampled only on bus_trn. bus_adr/bus_dat may change at any other time.

## Timing

- Reset values while rst is high and after release:
  - FSM=IDLE, cnt=0, pkt=0
  - str_vld=0, str_bus=8'h00
  - bus_rdy=0 while rst is high, 1 from the first cycle after release
- Latency: bus_trn on the edge ending cycle N gives byte 0 valid in cycle N+1.
- Throughput:
  - With str_rdy held at 1, one packet takes 8 cycles.
  - Consecutive transactions produce 8k contiguous str_vld cycles with no gap.
- Reset mid-packet:
  - The packet is abandoned immediately and str_vld drops asynchronously.
  - No partial packet resumes after reset.
- Wrap-around: cnt 7 -> 0 only through a new load or a return to IDLE. The counter is never free-running.

## Test plan

1. Single write, str_rdy=1:
   - Stimulus: adr=32'h1234_5678, dat=32'hDEAD_BEEF.
   - Required: str_bus sequence 78,56,34,12,EF,BE,AD,DE on 8 consecutive cycles starting the cycle after bus_trn.
   - Required: bus_rdy=0 during bytes 0..6; str_vld=0 afterwards.
2. Back-to-back transactions:
   - Stimulus: bus_vld held high with adr=1/dat=2, then adr=3/dat=4.
   - Required: 16 contiguous valid bytes 01,00,00,00,02,00,00,00,03,00,00,00,04,00,00,00.
   - Required: second bus_trn coincides with the byte-7 str_trn.
3. Backpressure:
   - Stimulus: str_rdy random at 50%.
   - Required: byte order is identical to scenario 1.
   - Required: str_bus/str_vld are stable during every stall and the byte count is exactly 8.
4. Stall on last byte:
   - Stimulus: str_rdy=0 at cnt==7 with bus_vld=1.
   - Required: bus_rdy=0 for the whole stall; the new transaction is accepted on the same cycle that str_rdy returns to 1.
5. Reset mid-packet:
   - Stimulus: assert rst after byte 3, then release.
   - Required: str_vld=0 immediately; bus_rdy=1 one cycle after release.
   - Required: the next transaction emits a complete, fresh 8-byte packet.
6. Loopback:
   - Stimulus: connect this block to the demux stage and issue 100 random adr/dat pairs.
   - Required: every pair reappears on the demux bus outputs in order.
